// File: rtl/pcileech_tx_pkg.sv
// Shared constants for the FT601 TX frame packer.
// Covers the frame geometry, the header field offsets and the FSM state codes.
package pcileech_tx_pkg;
    localparam logic [7:0] TX_MAGIC      = 8'hEF;
    localparam int         TX_NUM_SLOTS  = 7;
    localparam int         TX_SLOT_W     = 32;
    localparam int         TX_TYPE_W     = 2;
    localparam int         TX_HDR_LSB    = TX_NUM_SLOTS * TX_SLOT_W;   // 224
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_BMAP_LSB  = 14;
    localparam int         HDR_TYPE_LSB  = 0;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;
endpackage

// File: rtl/pcileech_tx_packer.sv
// Packs tagged 32-bit words into 256-bit FT601 frames: seven data slots plus a header.
// A partial frame is emitted on flush or after an idle timeout.
module pcileech_tx_packer
    import pcileech_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  in_data,
    input  logic [1:0]   in_type,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [255:0] dout,
    output logic         dout_wr_en,
    input  logic         dout_ready
);
    // The timeout fires on the idle cycle whose increment reaches TIMEOUT_CYCLES-1.
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 2);

    logic [0:0]                                 state;
    logic                                       run;
    logic [TX_NUM_SLOTS-1:0][TX_SLOT_W-1:0]     slot_data;
    logic [TX_NUM_SLOTS-1:0][TX_TYPE_W-1:0]     slot_type;
    logic [TX_NUM_SLOTS-1:0]                    bitmap;
    logic [2:0]                                 count;
    logic [15:0]                                idle_cnt;
    logic                                       accept;
    logic [3:0]                                 count_nxt;
    logic                                       go_emit;

    assign in_ready   = run && (state == ST_FILL);
    assign accept     = in_valid && in_ready;
    assign count_nxt  = {1'b0, count} + {3'b000, accept};
    assign dout_wr_en = (state == ST_EMIT) && dout_ready;

    always_comb begin
        go_emit = 1'b0;
        if (state == ST_FILL) begin
            if (accept && count == 3'(TX_NUM_SLOTS - 1))
                go_emit = 1'b1;
            else if (flush && count_nxt != 4'd0)
                go_emit = 1'b1;
            else if (!accept && count != 3'd0 && idle_cnt == IDLE_LAST)
                go_emit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            run       <= 1'b0;
            slot_data <= '0;
            slot_type <= '0;
            bitmap    <= '0;
            count     <= '0;
            idle_cnt  <= '0;
        end else begin
            run <= 1'b1;
            if (state == ST_FILL) begin
                if (accept) begin
                    for (int k = 0; k < TX_NUM_SLOTS; k++) begin
                        if (count == 3'(k)) begin
                            slot_data[k] <= in_data;
                            slot_type[k] <= in_type;
                            bitmap[k]    <= 1'b1;
                        end
                    end
                    count    <= count + 3'd1;
                    idle_cnt <= '0;
                end else if (count != 3'd0) begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
                if (go_emit)
                    state <= ST_EMIT;
            end else if (dout_ready) begin
                slot_data <= '0;
                slot_type <= '0;
                bitmap    <= '0;
                count     <= '0;
                idle_cnt  <= '0;
                state     <= ST_FILL;
            end
        end
    end

    // dout comes straight from flops; the header's magic/reserved bits are constants.
    assign dout = {TX_MAGIC, 3'b000, bitmap, slot_type, slot_data};

endmodule

// File: tb/tb_pcileech_tx_packer.sv
// Directed bench for pcileech_tx_packer: full frames, timeout, backpressure, flush, reset, streaming.
module tb_pcileech_tx_packer;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  in_data = '0;
    logic [1:0]   in_type = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         dout_ready = 1'b1;
    logic         in_ready;
    logic         dout_wr_en;
    logic [255:0] dout;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [255:0] frames[$];
    int           wr_cyc[$];

    pcileech_tx_packer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_type(in_type),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .dout(dout), .dout_wr_en(dout_wr_en), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dout_wr_en) begin
        frames.push_back(dout);
        wr_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        frames.delete();
        wr_cyc.delete();
    endtask

    // Offer one word (optionally with flush); returns one tick after the accepting edge.
    task automatic push(input logic [31:0] d, input logic [1:0] t, input logic fl);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_type = t; flush = fl;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) checkn("push_timeout", int'(in_ready), 1);
        last_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [255:0] exp;
        int bad, idx, s, n, acc7;

        // Reset state
        #1;
        @(negedge clk);
        checkn("rst_in_ready", int'(in_ready), 0);
        checkn("rst_wr_en", int'(dout_wr_en), 0);
        check("rst_dout", dout, {32'hEF000000, 224'd0});
        @(posedge clk); #1 rst_n = 1'b1;
        #1 checkn("ready_before_edge", int'(in_ready), 0);
        @(posedge clk); #1;
        checkn("ready_after_edge", int'(in_ready), 1);

        // Full frame; types 0,1,2,3,0,1,2 -> type field 0x24E4, bitmap 0x7F
        clear_log();
        for (int i = 0; i < 7; i++) push(32'(32'h11111111 * (i + 1)), 2'(i % 4), 1'b0);
        acc7 = last_acc;
        idle(3);
        checkn("full_nframes", frames.size(), 1);
        if (frames.size() == 1) begin
            check("full_frame", frames[0], {32'hEF1FE4E4, 32'h77777777, 32'h66666666, 32'h55555555,
                                            32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
            checkn("full_latency", wr_cyc[0] - acc7, 1);
        end

        // Timeout: 3 words types 1,2,3 -> type field 0x039, bitmap 0b0000111
        clear_log();
        push(32'hAAAA0001, 2'd1, 1'b0);
        push(32'hAAAA0002, 2'd2, 1'b0);
        push(32'hAAAA0003, 2'd3, 1'b0);
        idle(12);
        checkn("to_nframes", frames.size(), 1);
        if (frames.size() == 1) begin
            check("to_frame", frames[0], {32'hEF01C039, 128'd0, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001});
            checkn("to_latency", wr_cyc[0] - last_acc, 8);
        end

        // Backpressure: frame held 20 cycles, released with one strobe
        clear_log();
        dout_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(32'hB0000000 + 32'(i), 2'd3, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready || dout_wr_en) bad++;
        end
        checkn("bp_hold", bad, 0);
        checkn("bp_no_frames", frames.size(), 0);
        @(posedge clk); #1 dout_ready = 1'b1;
        @(negedge clk);
        checkn("bp_strobe", int'(dout_wr_en), 1);
        check("bp_frame", dout, {32'hEF1FFFFF, 32'hB0000007, 32'hB0000006, 32'hB0000005, 32'hB0000004,
                                 32'hB0000003, 32'hB0000002, 32'hB0000001});
        @(posedge clk); #1;
        @(negedge clk);
        checkn("bp_refill_ready", int'(in_ready), 1);
        checkn("bp_nframes", frames.size(), 1);

        // Flush with an empty frame is ignored
        clear_log();
        flush = 1'b1;
        idle(3);
        flush = 1'b0;
        idle(2);
        checkn("flush_empty_nframes", frames.size(), 0);
        checkn("flush_empty_ready", int'(in_ready), 1);

        // Flush together with word 7 -> one frame
        for (int i = 1; i <= 6; i++) push(32'hC0000000 + 32'(i), 2'd0, 1'b0);
        push(32'hC0000007, 2'd0, 1'b1);
        acc7 = last_acc;
        idle(12);
        checkn("flush7_nframes", frames.size(), 1);
        if (frames.size() == 1) begin
            check("flush7_frame", frames[0], {32'hEF1FC000, 32'hC0000007, 32'hC0000006, 32'hC0000005,
                                              32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001});
            checkn("flush7_latency", wr_cyc[0] - acc7, 1);
        end

        // Flush together with word 1 -> bitmap 0b0000001, type 2
        clear_log();
        push(32'hD0000001, 2'd2, 1'b1);
        idle(4);
        checkn("flush1_nframes", frames.size(), 1);
        if (frames.size() == 1) begin
            check("flush1_frame", frames[0], {32'hEF004002, 192'd0, 32'hD0000001});
            checkn("flush1_latency", wr_cyc[0] - last_acc, 1);
        end

        // Reset mid-frame discards the partial frame
        clear_log();
        for (int i = 1; i <= 4; i++) push(32'hF0000000 + 32'(i), 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        checkn("midrst_ready", int'(in_ready), 0);
        checkn("midrst_wr_en", int'(dout_wr_en), 0);
        check("midrst_dout", dout, {32'hEF000000, 224'd0});
        idle(2);
        rst_n = 1'b1;
        idle(12);
        checkn("midrst_nframes", frames.size(), 0);
        for (int i = 1; i <= 7; i++) push(32'hE0000000 + 32'(i), 2'd1, 1'b0);
        idle(3);
        checkn("postrst_nframes", frames.size(), 1);
        if (frames.size() == 1)
            check("postrst_frame", frames[0], {32'hEF1FD555, 32'hE0000007, 32'hE0000006, 32'hE0000005,
                                               32'hE0000004, 32'hE0000003, 32'hE0000002, 32'hE0000001});

        // Streaming: 70 words with in_valid held high -> 10 frames in 80 cycles
        clear_log();
        idx = 0; s = -1; n = 0;
        in_valid = 1'b1;
        while (idx < 70 && n < 200) begin
            in_data = 32'h50000000 + 32'(idx);
            in_type = 2'(idx % 4);
            @(negedge clk);
            if (in_ready) begin
                if (s < 0) s = cyc;
                idx++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        idle(4);
        checkn("stream_accepted", idx, 70);
        checkn("stream_nframes", frames.size(), 10);
        if (frames.size() == 10) checkn("stream_span", wr_cyc[9] - s, 79);
        for (int j = 0; j < frames.size() && j < 10; j++) begin
            exp = '0;
            exp[255:224] = {8'hEF, 3'b000, 7'h7F, 14'h0};
            for (int k = 0; k < 7; k++) begin
                exp[32*k +: 32]      = 32'h50000000 + 32'(7 * j + k);
                exp[224 + 2*k +: 2]  = 2'((7 * j + k) % 4);
            end
            check($sformatf("stream_frame%0d", j), frames[j], exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
